// File: rtl/sprite_pkg.sv
// Shared types, sprite bitmap and geometry helpers for the sprite renderer.
// The bitmap is a hollow 16x16 square with a main diagonal; bit 15 of each row is column 0.
package sprite_pkg;

  typedef logic [5:0] color_t;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  typedef struct packed {
    logic [9:0] pos;
    dir_t       dir;
    logic       bounce;
  } axis_t;

  localparam logic [15:0] SPRITE_BITMAP [16] = '{
    16'hFFFF, 16'hC001, 16'hA001, 16'h9001,
    16'h8801, 16'h8401, 16'h8201, 16'h8101,
    16'h8081, 16'h8041, 16'h8021, 16'h8011,
    16'h8009, 16'h8005, 16'h8003, 16'hFFFF
  };

  function automatic int box_size(input int scale_log2);
    return 16 << scale_log2;
  endfunction

  function automatic int travel_max(input int extent, input int scale_log2);
    return extent - box_size(scale_log2);
  endfunction

  // One frame of motion on one axis; the 11-bit sums cannot wrap.
  function automatic axis_t step_axis(input logic [9:0] pos, input dir_t dir,
                                      input int limit, input int speed);
    axis_t      r;
    logic [10:0] p;
    logic [10:0] s;
    logic [10:0] m;
    p = {1'b0, pos};
    s = 11'(speed);
    m = 11'(limit);
    r = '{pos: pos, dir: dir, bounce: 1'b0};
    if (dir == DIR_POS) begin
      if (p + s >= m) r = '{pos: m[9:0], dir: DIR_NEG, bounce: 1'b1};
      else            r.pos = 10'(p + s);
    end else begin
      if (p <= s) r = '{pos: 10'd0, dir: DIR_POS, bounce: 1'b1};
      else        r.pos = 10'(p - s);
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// Combinational row lookup into the sprite bitmap; column select is done by the caller.
module sprite_rom
  import sprite_pkg::*;
(
  input  logic [3:0]  row,
  output logic [15:0] bits
);

  assign bits = SPRITE_BITMAP[row];

endmodule

// File: rtl/sprite_renderer.sv
// Renders a bouncing, scaled 16x16 sprite over a flat background with a 2-cycle
// pixel pipeline; the sync pulses are delayed by the same 2 cycles.
module sprite_renderer
  import sprite_pkg::*;
#(
  parameter int     H_DISPLAY  = 640,
  parameter int     V_DISPLAY  = 480,
  parameter int     SCALE_LOG2 = 2,
  parameter int     SPEED      = 2,
  parameter color_t BG_COLOR   = 6'b000001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       pause,
  input  logic [5:0] fg_color,
  output logic [5:0] rgb,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [9:0] sprite_x,
  output logic [9:0] sprite_y,
  output logic       hit
);

  localparam int BOX   = box_size(SCALE_LOG2);
  localparam int X_MAX = travel_max(H_DISPLAY, SCALE_LOG2);
  localparam int Y_MAX = travel_max(V_DISPLAY, SCALE_LOG2);

  dir_t  dir_x, dir_y;
  axis_t step_x, step_y;
  logic  tick;

  // First blanking line, first pixel: moving here never tears the visible frame.
  assign tick   = (hpos == 10'd0) && (vpos == 10'(V_DISPLAY));
  assign step_x = step_axis(sprite_x, dir_x, X_MAX, SPEED);
  assign step_y = step_axis(sprite_y, dir_y, Y_MAX, SPEED);

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sprite_x <= '0;
      sprite_y <= '0;
      dir_x    <= DIR_POS;
      dir_y    <= DIR_POS;
      hit      <= 1'b0;
    end else if (tick && !pause) begin
      sprite_x <= step_x.pos;
      sprite_y <= step_y.pos;
      dir_x    <= step_x.dir;
      dir_y    <= step_y.dir;
      hit      <= step_x.bounce | step_y.bounce;
    end else begin
      hit      <= 1'b0;
    end
  end

  logic [10:0] h_ext, v_ext, x_ext, y_ext;
  logic        in_box_c;
  logic [3:0]  col_c, row_c;

  assign h_ext = {1'b0, hpos};
  assign v_ext = {1'b0, vpos};
  assign x_ext = {1'b0, sprite_x};
  assign y_ext = {1'b0, sprite_y};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    in_box_c = 1'b0;
    col_c    = 4'((h_ext - x_ext) >> SCALE_LOG2);
    row_c    = 4'((v_ext - y_ext) >> SCALE_LOG2);
    if (h_ext >= x_ext && h_ext < x_ext + 11'(BOX) &&
        v_ext >= y_ext && v_ext < y_ext + 11'(BOX))
      in_box_c = 1'b1;
  end

  logic       s1_in_box, s1_de;
  logic [3:0] s1_col, s1_row;
  logic [1:0] hs_q, vs_q;
  logic [15:0] rom_word;

  sprite_rom u_rom (
    .row  (s1_row),
    .bits (rom_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_in_box <= 1'b0;
      s1_de     <= 1'b0;
      s1_col    <= '0;
      s1_row    <= '0;
      hs_q      <= '0;
      vs_q      <= '0;
      rgb       <= '0;
    end else begin
      s1_in_box <= in_box_c;
      s1_de     <= display_on;
      s1_col    <= col_c;
      s1_row    <= row_c;
      hs_q      <= {hs_q[0], hsync_in};
      vs_q      <= {vs_q[0], vsync_in};
      if (!s1_de)                                    rgb <= '0;
      else if (s1_in_box && rom_word[4'd15 - s1_col]) rgb <= fg_color;
      else                                           rgb <= BG_COLOR;
    end
  end

  assign hsync_out = hs_q[1];
  assign vsync_out = vs_q[1];

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed + randomized bench for sprite_renderer against a behavioural model
// of sprite motion and pixel colouring.
module tb_sprite_renderer;

  logic       clk;
  logic       reset;
  logic [9:0] hpos, vpos;
  logic       display_on, hsync_in, vsync_in, pause;
  logic [5:0] fg_color;
  logic [5:0] rgb;
  logic       hsync_out, vsync_out, hit;
  logic [9:0] sprite_x, sprite_y;

  sprite_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .pause      (pause),
    .fg_color   (fg_color),
    .rgb        (rgb),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .hit        (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   ticks  = 0;
  int   mx, my;
  bit   mx_neg, my_neg;
  bit   exp_hit;
  logic hit_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mx = 0; my = 0; mx_neg = 0; my_neg = 0;
  endfunction

  function automatic void move_axis(inout int p, inout bit neg, input int lim, output bit b);
    b = 0;
    if (!neg) begin
      if (p + 2 >= lim) begin p = lim; neg = 1; b = 1; end
      else p = p + 2;
    end else begin
      if (p <= 2) begin p = 0; neg = 0; b = 1; end
      else p = p - 2;
    end
  endfunction

  function automatic logic [5:0] model_pixel(input int h, input int v, input bit de,
                                             input logic [5:0] f);
    int r, c;
    if (!de) return 6'd0;
    if (h >= mx && h < mx + 64 && v >= my && v < my + 64) begin
      c = (h - mx) / 4;
      r = (v - my) / 4;
      if (r == 0 || r == 15 || c == 0 || c == 15 || r == c) return f;
    end
    return 6'b000001;
  endfunction

  task automatic idle_inputs();
    hpos = 10'd1; vpos = 10'd0; display_on = 1'b0;
  endtask

  task automatic do_tick(input string tag);
    bit bx, by;
    @(negedge clk);
    hpos = 10'd0; vpos = 10'd480; display_on = 1'b0;
    @(negedge clk);
    idle_inputs();
    bx = 0; by = 0;
    if (!pause) begin
      move_axis(mx, mx_neg, 576, bx);
      move_axis(my, my_neg, 416, by);
      ticks++;
    end
    exp_hit  = (bx || by) && !pause;
    hit_seen = hit;
    check({tag, " sprite_x"}, 32'(sprite_x), mx);
    check({tag, " sprite_y"}, 32'(sprite_y), my);
    check({tag, " hit"}, 32'(hit), 32'(exp_hit));
    @(negedge clk);
    check({tag, " hit falls"}, 32'(hit), 0);
  endtask

  task automatic pixel(input string tag, input int h, input int v, input bit de,
                       input logic [5:0] f);
    logic [5:0] exp;
    exp = model_pixel(h, v, de, f);
    @(negedge clk);
    hpos = 10'(h); vpos = 10'(v); display_on = de;
    @(negedge clk);
    idle_inputs();
    fg_color = f;
    @(negedge clk);
    check(tag, 32'(rgb), 32'(exp));
  endtask

  task automatic random_pixels(input int n);
    int h, v;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        h = (mx >= 2 ? mx - 2 : mx) + int'($urandom_range(0, 68));
        v = (my >= 2 ? my - 2 : my) + int'($urandom_range(0, 68));
      end else begin
        h = int'($urandom_range(0, 799));
        v = int'($urandom_range(0, 524));
      end
      if (h == 0 && v == 480) h = 1;
      pixel("random pixel", h, v, ($urandom_range(0, 7) != 0), 6'($urandom_range(0, 63)));
    end
  endtask

  task automatic sync_test(input bit vert, input string tag);
    int width;
    bit exp;
    width = 0;
    for (int i = 0; i < 104; i++) begin
      @(negedge clk);
      exp = (i - 2 >= 2) && (i - 2 < 98);
      check(tag, 32'(vert ? vsync_out : hsync_out), 32'(exp));
      if (vert ? vsync_out : hsync_out) width++;
      if (vert) vsync_in = (i >= 2 && i < 98);
      else      hsync_in = (i >= 2 && i < 98);
    end
    check({tag, " width"}, width, 96);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " rgb"}, 32'(rgb), 0);
    check({tag, " hsync_out"}, 32'(hsync_out), 0);
    check({tag, " vsync_out"}, 32'(vsync_out), 0);
    check({tag, " sprite_x"}, 32'(sprite_x), 0);
    check({tag, " sprite_y"}, 32'(sprite_y), 0);
    check({tag, " hit"}, 32'(hit), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  int save_x, save_y;

  initial begin
    // Reset with busy, in-box inputs and both syncs high.
    reset = 1'b1; pause = 1'b0; fg_color = 6'h3F;
    hpos = 10'd5; vpos = 10'd5; display_on = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    idle_inputs();
    model_reset();

    do_tick("first tick");
    check("first tick x=2", 32'(sprite_x), 2);
    pixel("pixel (2,2)",   2,  2, 1'b1, 6'b110000);
    check("pixel (2,2) fg", 32'(rgb), 32'(6'b110000));
    pixel("pixel (6,10)",  6, 10, 1'b1, 6'b110000);
    pixel("pixel (10,10)", 10, 10, 1'b1, 6'b110000);
    pixel("pixel (66,2)", 66,  2, 1'b1, 6'b110000);
    check("pixel (66,2) bg", 32'(rgb), 32'(6'b000001));

    while (ticks < 208) do_tick("run to y bounce");
    check("tick 208 sprite_y", 32'(sprite_y), 416);
    check("tick 208 hit", 32'(hit_seen), 1);
    do_tick("tick 209");
    check("tick 209 sprite_y", 32'(sprite_y), 414);
    while (ticks < 288) do_tick("run to x bounce");
    check("tick 288 sprite_x", 32'(sprite_x), 576);
    check("tick 288 hit", 32'(hit_seen), 1);
    do_tick("tick 289");
    check("tick 289 sprite_x", 32'(sprite_x), 574);

    random_pixels(150);

    save_x = int'(sprite_x); save_y = int'(sprite_y);
    @(negedge clk); pause = 1'b1;
    repeat (5) do_tick("paused tick");
    check("pause held x", 32'(sprite_x), save_x);
    check("pause held y", 32'(sprite_y), save_y);
    @(negedge clk); pause = 1'b0;
    do_tick("after pause");
    check("after pause x moved 2", save_x - int'(sprite_x), 2);
    check("after pause y moved 2", save_y - int'(sprite_y), 2);

    pixel("blanked in-box pixel", mx + 1, my + 1, 1'b0, 6'b110000);
    check("blanked rgb zero", 32'(rgb), 0);
    sync_test(1'b0, "hsync align");
    sync_test(1'b1, "vsync align");

    // Mid-frame reset: must take effect on the very next edge.
    @(negedge clk);
    hpos = 10'(mx + 1); vpos = 10'(my); display_on = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b1; reset = 1'b1;
    @(negedge clk);
    check("mid reset 1 cycle sprite_x", 32'(sprite_x), 0);
    check("mid reset 1 cycle rgb", 32'(rgb), 0);
    repeat (2) @(negedge clk);
    check_reset_state("mid reset");
    reset = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    idle_inputs();
    model_reset();
    ticks = 0;
    pixel("first pixel after reset", 0, 0, 1'b1, 6'b001100);

    // Both axes bounce together at tick 3744: x at 576, y at 0.
    while (ticks < 3744) do_tick("corner run");
    check("corner sprite_x", 32'(sprite_x), 576);
    check("corner sprite_y", 32'(sprite_y), 0);
    check("corner hit", 32'(hit_seen), 1);
    do_tick("after corner");
    check("after corner x", 32'(sprite_x), 574);
    check("after corner y", 32'(sprite_y), 2);

    random_pixels(150);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
